// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module  : mem_wb_stage
// Brief   : MIPS MEM/WB stage that runs data-memory loads and stores over a
//           req/ack handshake and drives the register-file write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_regWrite,
  input  logic        ex_memToReg,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [31:0] ex_aluResult,
  input  logic [31:0] ex_storeData,
  input  logic [4:0]  ex_writeReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        regWrite,
  output logic [4:0]  writeReg_MEM_WB,
  output logic [31:0] writeData_MEM_WB,
  output logic        wb_valid,
  output logic        mem_error
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [4:0]         dest_q;
  logic               rw_q;
  logic               m2r_q;
  logic               regwrite_q;
  logic               wb_valid_q;
  logic               mem_error_q;
  logic [4:0]         wreg_q;
  logic [31:0]        wbdata_q;

  logic               is_mem_d;
  logic               misaligned_d;
  logic               timeout_d;
  logic [31:0]        wbdata_d;

  assign is_mem_d     = ex_memRead | ex_memWrite;
  assign misaligned_d = |ex_aluResult[1:0];
  assign timeout_d    = (cnt_q == C_CNT_LAST);
  // Only a load with memToReg takes memory data; everything else returns the ALU value.
  assign wbdata_d     = (m2r_q && !we_q) ? dmem_rdata : addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      regwrite_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      mem_error_q <= 1'b0;
      wreg_q      <= '0;
      wbdata_q    <= '0;
    end else begin
      regwrite_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      mem_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem_d) begin
              wreg_q     <= ex_writeReg;
              wbdata_q   <= ex_aluResult;
              wb_valid_q <= 1'b1;
              regwrite_q <= ex_regWrite && (ex_writeReg != 5'd0);
            end else if (misaligned_d) begin
              mem_error_q <= 1'b1;
              wb_valid_q  <= 1'b1;
            end else begin
              state_q <= ACCESS;
              req_q   <= 1'b1;
              we_q    <= ex_memWrite;
              addr_q  <= ex_aluResult;
              wdata_q <= ex_storeData;
              dest_q  <= ex_writeReg;
              rw_q    <= ex_regWrite;
              m2r_q   <= ex_memToReg;
              cnt_q   <= '0;
            end
          end
        end
        ACCESS: begin
          // An ack on the timeout edge still completes normally.
          if (dmem_ack) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            regwrite_q <= !we_q && rw_q && (dest_q != 5'd0);
            wreg_q     <= dest_q;
            wbdata_q   <= wbdata_d;
          end else if (timeout_d) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            mem_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall            = (state_q == ACCESS);
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign regWrite         = regwrite_q;
  assign writeReg_MEM_WB  = wreg_q;
  assign writeData_MEM_WB = wbdata_q;
  assign wb_valid         = wb_valid_q;
  assign mem_error        = mem_error_q;

endmodule

`default_nettype wire
